// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single GPR write port.
// LSU > MDU > ALU, with starvation promotion for MDU/ALU.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int IDXW         = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,

  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [IDXW-1:0] i_lsu_rdidx,
  input  logic [XLEN-1:0] i_lsu_wdata,

  input  logic            i_mdu_valid,
  output logic            o_mdu_ready,
  input  logic [IDXW-1:0] i_mdu_rdidx,
  input  logic [XLEN-1:0] i_mdu_wdata,

  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [IDXW-1:0] i_alu_rdidx,
  input  logic [XLEN-1:0] i_alu_wdata,

  output logic            o_rdwen,
  output logic [IDXW-1:0] o_rdidx,
  output logic [XLEN-1:0] o_rd_wdata
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]      r_mdu_wait;
  logic [3:0]      r_alu_wait;
  logic            r_rdwen;
  logic [IDXW-1:0] r_rdidx;
  logic [XLEN-1:0] r_wdata;

  logic            w_mdu_prom;
  logic            w_alu_prom;
  logic            w_gnt_lsu;
  logic            w_gnt_mdu;
  logic            w_gnt_alu;
  logic            w_any;
  logic [IDXW-1:0] w_sel_idx;
  logic [XLEN-1:0] w_sel_dat;

  // A saturated waiter only counts as promoted while it is asking.
  assign w_mdu_prom = i_mdu_valid && (r_mdu_wait == LIM);
  assign w_alu_prom = i_alu_valid && (r_alu_wait == LIM);

  // Pick one winner: promoted MDU, promoted ALU, then LSU > MDU > ALU.
  always_comb begin
    w_gnt_lsu = 1'b0;
    w_gnt_mdu = 1'b0;
    w_gnt_alu = 1'b0;
    if (i_rstn) begin
      priority case (1'b1)
        w_mdu_prom:  w_gnt_mdu = 1'b1;
        w_alu_prom:  w_gnt_alu = 1'b1;
        i_lsu_valid: w_gnt_lsu = 1'b1;
        i_mdu_valid: w_gnt_mdu = 1'b1;
        i_alu_valid: w_gnt_alu = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_any       = w_gnt_lsu | w_gnt_mdu | w_gnt_alu;
  assign o_lsu_ready = w_gnt_lsu;
  assign o_mdu_ready = w_gnt_mdu;
  assign o_alu_ready = w_gnt_alu;

  // Steer the winner's index and data toward the output register.
  always_comb begin
    w_sel_idx = '0;
    w_sel_dat = '0;
    unique case (1'b1)
      w_gnt_lsu: begin
        w_sel_idx = i_lsu_rdidx;
        w_sel_dat = i_lsu_wdata;
      end
      w_gnt_mdu: begin
        w_sel_idx = i_mdu_rdidx;
        w_sel_dat = i_mdu_wdata;
      end
      w_gnt_alu: begin
        w_sel_idx = i_alu_rdidx;
        w_sel_dat = i_alu_wdata;
      end
      default: ;
    endcase
  end

  // MDU wait counter: counts blocked cycles, clears on grant or idle.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_mdu_wait <= '0;
    end else if (!i_mdu_valid || w_gnt_mdu) begin
      r_mdu_wait <= '0;
    end else if (r_mdu_wait != LIM) begin
      r_mdu_wait <= r_mdu_wait + 4'd1;
    end
  end

  // ALU wait counter: same rules; stays saturated if MDU beats it.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_alu_wait <= '0;
    end else if (!i_alu_valid || w_gnt_alu) begin
      r_alu_wait <= '0;
    end else if (r_alu_wait != LIM) begin
      r_alu_wait <= r_alu_wait + 4'd1;
    end
  end

  // Register the granted write; x0 completes but never writes.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rdwen <= 1'b0;
      r_rdidx <= '0;
      r_wdata <= '0;
    end else if (w_any) begin
      r_rdwen <= (w_sel_idx != '0);
      r_rdidx <= w_sel_idx;
      r_wdata <= w_sel_dat;
    end else begin
      r_rdwen <= 1'b0;
    end
  end

  assign o_rdwen    = r_rdwen;
  assign o_rdidx    = r_rdidx;
  assign o_rd_wdata = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random
// traffic against a queue-based priority reference model.
module tb_wb_arbiter;

  localparam int LIM = 4;

  logic        clk;
  logic        rstn;
  logic        v   [3];
  logic [4:0]  idx [3];
  logic [31:0] dat [3];
  logic        lsu_rdy, mdu_rdy, alu_rdy;
  logic        rdwen;
  logic [4:0]  rdidx;
  logic [31:0] rdwdata;

  int total = 0;
  int bad   = 0;

  int w [3];
  logic        exp_wen;
  logic [4:0]  exp_idx;
  logic [31:0] exp_dat;
  int          last_g;

  logic [2:0]  seen_rdy;
  logic        seen_wen;
  logic [4:0]  seen_idx;
  logic [31:0] seen_dat;

  wb_arbiter #(.XLEN(32), .IDXW(5), .STARVE_LIMIT(LIM)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_lsu_valid(v[0]),
    .o_lsu_ready(lsu_rdy),
    .i_lsu_rdidx(idx[0]),
    .i_lsu_wdata(dat[0]),
    .i_mdu_valid(v[1]),
    .o_mdu_ready(mdu_rdy),
    .i_mdu_rdidx(idx[1]),
    .i_mdu_wdata(dat[1]),
    .i_alu_valid(v[2]),
    .o_alu_ready(alu_rdy),
    .i_alu_rdidx(idx[2]),
    .i_alu_wdata(dat[2]),
    .o_rdwen    (rdwen),
    .o_rdidx    (rdidx),
    .o_rd_wdata (rdwdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: promoted waiters first (MDU before ALU), then
  // the valid sources in fixed order; first in line wins.
  function automatic int pick();
    int line[$];
    if (!rstn) return -1;
    if (v[1] && w[1] == LIM) line.push_back(1);
    if (v[2] && w[2] == LIM) line.push_back(2);
    for (int s = 0; s < 3; s++)
      if (v[s]) line.push_back(s);
    if (line.size() == 0) return -1;
    return line[0];
  endfunction

  // One clock: check at negedge, advance the model, step past posedge.
  task automatic step();
    int g;
    logic [2:0] er;
    @(negedge clk);
    g  = pick();
    er = 3'b000;
    if (g >= 0) er[g] = 1'b1;
    seen_rdy = {alu_rdy, mdu_rdy, lsu_rdy};
    seen_wen = rdwen;
    seen_idx = rdidx;
    seen_dat = rdwdata;
    chk("ready", 64'(seen_rdy), 64'(er));
    chk("rdwen", 64'(seen_wen), 64'(exp_wen));
    if (exp_wen) begin
      chk("rdidx", 64'(seen_idx), 64'(exp_idx));
      chk("wdata", 64'(seen_dat), 64'(exp_dat));
    end
    last_g = g;
    if (!rstn) begin
      w[1] = 0; w[2] = 0;
      exp_wen = 1'b0; exp_idx = '0; exp_dat = '0;
    end else begin
      for (int s = 1; s < 3; s++) begin
        if (!v[s] || g == s) w[s] = 0;
        else if (w[s] < LIM) w[s]++;
      end
      if (g >= 0) begin
        exp_wen = (idx[g] != 0);
        exp_idx = idx[g];
        exp_dat = dat[g];
      end else begin
        exp_wen = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int s = 0; s < 3; s++) v[s] = 1'b0;
    step();
    step();
  endtask

  initial begin
    rstn = 1'b0;
    for (int s = 0; s < 3; s++) begin
      v[s] = 1'b0; idx[s] = '0; dat[s] = '0; w[s] = 0;
    end
    exp_wen = 1'b0; exp_idx = '0; exp_dat = '0;
    last_g = -1;
    step();
    step();
    chk("rst_wen", 64'(seen_wen), 64'd0);
    chk("rst_idx", 64'(seen_idx), 64'd0);
    chk("rst_dat", 64'(seen_dat), 64'd0);
    chk("rst_rdy", 64'(seen_rdy), 64'd0);
    rstn = 1'b1;
    idle();

    // single ALU write
    v[2] = 1'b1; idx[2] = 5'd5; dat[2] = 32'hDEADBEEF;
    step();
    chk("alu1_rdy", 64'(seen_rdy), 64'b100);
    v[2] = 1'b0;
    step();
    chk("alu1_wen", 64'(seen_wen), 64'd1);
    chk("alu1_idx", 64'(seen_idx), 64'd5);
    chk("alu1_dat", 64'(seen_dat), 64'hDEADBEEF);
    step();
    chk("alu1_off", 64'(seen_wen), 64'd0);
    idle();

    // all three together
    for (int s = 0; s < 3; s++) begin
      v[s] = 1'b1; idx[s] = 5'(s + 1); dat[s] = 32'(100 + s);
    end
    step();
    chk("all_g0", 64'(seen_rdy), 64'b001);
    v[0] = 1'b0;
    step();
    chk("all_g1", 64'(seen_rdy), 64'b010);
    chk("all_i1", 64'(seen_idx), 64'd1);
    v[1] = 1'b0;
    step();
    chk("all_g2", 64'(seen_rdy), 64'b100);
    chk("all_i2", 64'(seen_idx), 64'd2);
    chk("all_w2", 64'(seen_wen), 64'd1);
    v[2] = 1'b0;
    step();
    chk("all_i3", 64'(seen_idx), 64'd3);
    chk("all_w3", 64'(seen_wen), 64'd1);
    idle();

    // ALU starvation behind a constant LSU
    v[0] = 1'b1; v[2] = 1'b1; idx[2] = 5'd9; dat[2] = 32'h99;
    for (int c = 0; c < 4; c++) begin
      idx[0] = 5'(c + 10); dat[0] = 32'(c);
      step();
      chk("stv_blk", 64'(seen_rdy), 64'b001);
    end
    idx[0] = 5'd20;
    step();
    chk("stv_alu", 64'(seen_rdy), 64'b100);
    v[2] = 1'b0;
    step();
    chk("stv_lsu", 64'(seen_rdy), 64'b001);
    chk("stv_idx", 64'(seen_idx), 64'd9);
    idle();

    // write to x0
    v[2] = 1'b1; idx[2] = 5'd0; dat[2] = 32'h1234;
    step();
    chk("x0_rdy", 64'(seen_rdy), 64'b100);
    v[2] = 1'b0;
    step();
    chk("x0_wen", 64'(seen_wen), 64'd0);
    idle();

    // reset landing on an LSU grant
    v[0] = 1'b1; idx[0] = 5'd7; dat[0] = 32'h77;
    rstn = 1'b0;
    step();
    chk("mrst_rdy", 64'(seen_rdy), 64'd0);
    rstn = 1'b1;
    step();
    chk("mrst_wen", 64'(seen_wen), 64'd0);
    chk("mrst_idx", 64'(seen_idx), 64'd0);
    chk("mrst_dat", 64'(seen_dat), 64'd0);
    chk("mrst_gnt", 64'(seen_rdy), 64'b001);
    v[0] = 1'b0;
    step();
    chk("mrst_w7", 64'(seen_wen), 64'd1);
    chk("mrst_i7", 64'(seen_idx), 64'd7);
    idle();

    // double promotion
    for (int s = 0; s < 3; s++) begin
      v[s] = 1'b1; idx[s] = 5'(s + 4); dat[s] = 32'(s);
    end
    for (int c = 0; c < 4; c++) begin
      idx[0] = 5'(c + 12);
      step();
      chk("dbl_blk", 64'(seen_rdy), 64'b001);
    end
    step();
    chk("dbl_mdu", 64'(seen_rdy), 64'b010);
    idx[1] = 5'd30;
    step();
    chk("dbl_alu", 64'(seen_rdy), 64'b100);
    v[2] = 1'b0;
    step();
    chk("dbl_lsu", 64'(seen_rdy), 64'b001);
    idle();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 79) != 0);
      for (int s = 0; s < 3; s++) begin
        if (last_g == s || !v[s]) begin
          v[s]   = ($urandom_range(0, 9) < (s == 0 ? 8 : 5));
          idx[s] = 5'($urandom);
          dat[s] = $urandom;
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
